// File: rtl/sha_256_stream_core_pkg.sv
// sha_256_pkg: shared constants, types and bit functions for the streaming
// SHA-256/SHA-224 core.
//   hash_state_t : eight 32-bit words, element 0 (a / H0) most significant
//   state_t      : control FSM states
//   K, IV_256, IV_224 : round constants and initial hash values
package sha_256_pkg;

  typedef logic [0:7][31:0] hash_state_t;

  typedef enum logic [1:0] {S_IDLE, S_ROUNDS, S_UPDATE, S_OUTPUT} state_t;

  localparam hash_state_t IV_256 = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  localparam hash_state_t IV_224 = {
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

endpackage

// File: rtl/sha_256_stream_core_if.sv
// Block-in / digest-out handshake bundle of the streaming SHA core.
//   master : block producer and digest consumer
//   slave  : the hash core
interface sha_256_stream_core_if;
  logic [511:0] input_data;
  logic         input_valid;
  logic         input_first;
  logic         input_last;
  logic         mode;
  logic         input_ready;
  logic [255:0] output_hash;
  logic         output_valid;
  logic         output_ready;

  modport master (
    output input_data, input_valid, input_first, input_last, mode, output_ready,
    input  input_ready, output_hash, output_valid
  );

  modport slave (
    input  input_data, input_valid, input_first, input_last, mode, output_ready,
    output input_ready, output_hash, output_valid
  );
endinterface

// File: rtl/sha_256_stream_core_round.sv
// sha_256_round: one combinational SHA-256 compression round.
//   state_in  : working variables a..h
//   k, w      : round constant and schedule word
//   state_out : a..h after the round
module sha_256_round
  import sha_256_pkg::*;
(
  input  hash_state_t state_in,
  input  logic [31:0] k,
  input  logic [31:0] w,
  output hash_state_t state_out
);
  logic [31:0] t1;
  logic [31:0] t2;

  assign t1 = state_in[7] + big_sigma1(state_in[4]) + ch(state_in[4], state_in[5], state_in[6]) + k + w;
  assign t2 = big_sigma0(state_in[0]) + maj(state_in[0], state_in[1], state_in[2]);

  assign state_out = {t1 + t2, state_in[0], state_in[1], state_in[2],
                      state_in[3] + t1, state_in[4], state_in[5], state_in[6]};
endmodule

// File: rtl/sha_256_stream_core.sv
// sha_256_stream_core: multi-block streaming SHA-256 / SHA-224 engine.
// Takes pre-padded 512-bit blocks, chains the intermediate hash across
// blocks and presents a digest after the last block of a message.
//   clk, rst : clock and synchronous active-high reset
//   ena      : global enable, freezes all state when low
//   bus      : block input / digest output handshake (slave side)
module sha_256_stream_core
  import sha_256_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter bit SUPPORT_224      = 1
) (
  input logic clk,
  input logic rst,
  input logic ena,
  sha_256_stream_core_if.slave bus
);
  localparam int R = ROUNDS_PER_CYCLE;

  if (!(R == 1 || R == 2 || R == 4)) begin : gen_bad_rounds
    $error("ROUNDS_PER_CYCLE must be 1, 2 or 4");
  end

  state_t      state_reg;
  logic [5:0]  t_reg;
  logic [31:0] w_reg [0:15];
  logic [31:0] w_shift [0:15];
  hash_state_t work_reg;
  hash_state_t chain_reg;
  hash_state_t round_out;
  hash_state_t sum_next;
  hash_state_t iv_sel;
  logic        mode_sel;
  logic        mode_reg;
  logic        last_reg;
  logic        out_valid_reg;
  logic [255:0] out_hash_reg;

  assign mode_sel = SUPPORT_224 ? bus.mode : 1'b0;
  assign iv_sel   = mode_sel ? IV_224 : IV_256;

  // New schedule words beyond the window. Only W[t+14], W[t+15] can be
  // needed from further than the window start, and for R = 4 those are the
  // two words just produced by earlier lanes.
  genvar gi;
  for (gi = 0; gi < R; gi++) begin : gen_sched
    logic [31:0] w_calc;
    if (gi < 2) begin : gen_from_window
      assign w_calc = small_sigma1(w_reg[14 + gi]) + w_reg[9 + gi] + small_sigma0(w_reg[1 + gi]) + w_reg[gi];
    end else begin : gen_from_lane
      assign w_calc = small_sigma1(gen_sched[gi - 2].w_calc) + w_reg[9 + gi] + small_sigma0(w_reg[1 + gi]) + w_reg[gi];
    end
  end

  // Window advances by R words; the tail is filled with the new words.
  for (gi = 0; gi < 16; gi++) begin : gen_shift
    if (gi + R < 16) begin : gen_keep
      assign w_shift[gi] = w_reg[gi + R];
    end else begin : gen_fill
      assign w_shift[gi] = gen_sched[gi + R - 16].w_calc;
    end
  end

  // Rounds t..t+R-1 in a combinational chain; lane gi uses W[t+gi] = w_reg[gi].
  for (gi = 0; gi < R; gi++) begin : gen_round
    hash_state_t st_in;
    hash_state_t st_out;
    if (gi == 0) begin : gen_head
      assign st_in = work_reg;
    end else begin : gen_link
      assign st_in = gen_round[gi - 1].st_out;
    end
    sha_256_round u_round (
      .state_in  (st_in),
      .k         (K[t_reg + 6'(gi)]),
      .w         (w_reg[gi]),
      .state_out (st_out)
    );
  end
  assign round_out = gen_round[R - 1].st_out;

  for (gi = 0; gi < 8; gi++) begin : gen_sum
    assign sum_next[gi] = chain_reg[gi] + work_reg[gi];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      t_reg         <= '0;
      work_reg      <= '0;
      chain_reg     <= IV_256;
      mode_reg      <= 1'b0;
      last_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
      out_hash_reg  <= '0;
      for (int j = 0; j < 16; j++) w_reg[j] <= '0;
    end else if (ena) begin
      case (state_reg)
        S_IDLE: begin
          // ena is high and rst low here, so input_ready is asserted.
          if (bus.input_valid) begin
            for (int j = 0; j < 16; j++) w_reg[j] <= bus.input_data[511 - 32*j -: 32];
            if (bus.input_first) begin
              chain_reg <= iv_sel;
              mode_reg  <= mode_sel;
              work_reg  <= iv_sel;
            end else begin
              work_reg  <= chain_reg;
            end
            last_reg  <= bus.input_last;
            t_reg     <= '0;
            state_reg <= S_ROUNDS;
          end
        end
        S_ROUNDS: begin
          work_reg <= round_out;
          for (int j = 0; j < 16; j++) w_reg[j] <= w_shift[j];
          t_reg <= t_reg + 6'(R);
          if (t_reg == 6'(64 - R)) state_reg <= S_UPDATE;
        end
        S_UPDATE: begin
          chain_reg <= sum_next;
          if (last_reg) begin
            out_hash_reg  <= mode_reg ? {sum_next[0:6], 32'h0} : sum_next;
            out_valid_reg <= 1'b1;
            state_reg     <= S_OUTPUT;
          end else begin
            state_reg <= S_IDLE;
          end
        end
        S_OUTPUT: begin
          if (bus.output_ready) begin
            // Digest delivered: chain returns to the SHA-256 IV for a
            // following block that arrives without input_first.
            out_valid_reg <= 1'b0;
            chain_reg     <= IV_256;
            mode_reg      <= 1'b0;
            state_reg     <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign bus.input_ready  = ena & (state_reg == S_IDLE) & ~rst;
  assign bus.output_valid = out_valid_reg;
  assign bus.output_hash  = out_hash_reg;
endmodule

// File: tb/tb_sha_256_stream_core.sv
// Self-checking bench: three cores (1, 2, 4 rounds per cycle) checked against
// known digests and a block-level SHA-256 reference model.
module tb_sha_256_stream_core;
  localparam logic [255:0] IV256 = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] IV224 = 256'hc1059ed8367cd5073070dd17f70e5939ffc00b316858151164f98fa7befa4fa4;
  localparam logic [511:0] ABC_BLK = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] TWO_BLK1 = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869, 32'h6768696a,
    32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071,
    32'h80000000, 32'h00000000};
  localparam logic [511:0] TWO_BLK2 = {448'h0, 32'h0, 32'h000001c0};
  localparam logic [255:0] ABC256 = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] TWO256 = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [255:0] ABC224 = 256'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da700000000;

  logic clk = 1'b0;
  logic rst, ena;
  logic [511:0] in_data;
  logic in_first, in_last, in_mode, out_ready;
  logic in_valid [3];
  logic in_ready [3];
  logic out_valid [3];
  logic [255:0] out_hash [3];

  int n_checks = 0;
  int n_fail   = 0;
  logic [255:0] m_chain [3];
  logic         m_mode  [3];

  always #5 clk = ~clk;

  genvar gi;
  for (gi = 0; gi < 3; gi++) begin : gen_dut
    sha_256_stream_core_if bus ();
    assign bus.input_data   = in_data;
    assign bus.input_valid  = in_valid[gi];
    assign bus.input_first  = in_first;
    assign bus.input_last   = in_last;
    assign bus.mode         = in_mode;
    assign bus.output_ready = out_ready;
    assign in_ready[gi]  = bus.input_ready;
    assign out_valid[gi] = bus.output_valid;
    assign out_hash[gi]  = bus.output_hash;
    sha_256_stream_core #(.ROUNDS_PER_CYCLE(1 << gi), .SUPPORT_224(1'b1)) dut (
      .clk (clk), .rst (rst), .ena (ena), .bus (bus)
    );
  end

  task automatic check_value(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: whole-block compression with a full 64-word schedule.
  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] t1, t2;
    logic [255:0] res;
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++)
      w[i] = w[i-16] + (rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-7]
           + (rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10));
    for (int i = 0; i < 8; i++) v[i] = hin[255 - 32*i -: 32];
    for (int i = 0; i < 64; i++) begin
      t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6]))
         + sha_256_pkg::K[i] + w[i];
      t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int j = 7; j > 0; j--) v[j] = v[j-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) res[255 - 32*i -: 32] = hin[255 - 32*i -: 32] + v[i];
    return res;
  endfunction

  task automatic model_block(input int d, input logic [511:0] data, input logic first, input logic last,
                             input logic md, output logic [255:0] exp);
    if (first) begin
      m_chain[d] = md ? IV224 : IV256;
      m_mode[d]  = md;
    end
    m_chain[d] = compress(m_chain[d], data);
    exp = m_mode[d] ? {m_chain[d][255:32], 32'h0} : m_chain[d];
    if (last) begin
      m_chain[d] = IV256;
      m_mode[d]  = 1'b0;
    end
  endtask

  // Drives one block; returns 1 ns after the accept edge.
  task automatic send_block(input int d, input logic [511:0] data, input logic first, input logic last,
                            input logic md);
    int n = 0;
    while (!in_ready[d] && n < 300) begin @(posedge clk); #1; n++; end
    check_value("ready_seen", {255'h0, in_ready[d]}, 256'h1);
    in_data = data; in_first = first; in_last = last; in_mode = md;
    in_valid[d] = 1'b1;
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
  endtask

  task automatic wait_digest(input int d, input int start, output int lat, output logic [255:0] h);
    lat = start;
    while (!out_valid[d] && lat < start + 300) begin @(posedge clk); #1; lat++; end
    check_value("valid_seen", {255'h0, out_valid[d]}, 256'h1);
    h = out_hash[d];
  endtask

  task automatic take_digest(input int d);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_value("valid_clear", {255'h0, out_valid[d]}, 256'h0);
  endtask

  // Waits for the core to be ready again after a non-last block.
  task automatic wait_idle(input int d, output int lat);
    logic saw = 1'b0;
    lat = 0;
    while (!in_ready[d] && lat < 300) begin
      @(posedge clk); #1; lat++;
      saw |= out_valid[d];
    end
    check_value("no_valid_midmsg", {255'h0, saw}, 256'h0);
    check_value("ready_after_block", {255'h0, in_ready[d]}, 256'h1);
  endtask

  task automatic run_abc(input int d, input logic md, input logic [255:0] exp, input string tag);
    int lat;
    logic [255:0] h;
    send_block(d, ABC_BLK, 1'b1, 1'b1, md);
    wait_digest(d, 0, lat, h);
    $display("[tb] R=%0d %s lat=%0d hash=%h", 1 << d, tag, lat, h);
    check_value({tag, "_hash"}, h, exp);
    check_value({tag, "_latency"}, 256'(lat), 256'((64 >> d) + 1));
    take_digest(d);
  endtask

  initial begin
    int lat, lat2, stable;
    logic [255:0] h, exp;
    logic [511:0] blk;
    int nblk;
    logic first, last, md;

    rst = 1'b1; ena = 1'b1; in_data = '0; in_first = 0; in_last = 0; in_mode = 0; out_ready = 0;
    for (int d = 0; d < 3; d++) in_valid[d] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      check_value("rst_ready", {255'h0, in_ready[d]}, 256'h0);
      check_value("rst_valid", {255'h0, out_valid[d]}, 256'h0);
      check_value("rst_hash", out_hash[d], 256'h0);
    end
    rst = 1'b0;
    #1;
    check_value("ready_after_rst", {255'h0, in_ready[0]}, 256'h1);

    // Known-answer "abc" on all three round widths.
    for (int d = 0; d < 3; d++) run_abc(d, 1'b0, ABC256, "abc256");

    // Two-block message.
    send_block(0, TWO_BLK1, 1'b1, 1'b0, 1'b0);
    wait_idle(0, lat);
    $display("[tb] R=1 two-block blk1 ready_after=%0d", lat);
    check_value("block_period", 256'(lat), 256'd65);
    send_block(0, TWO_BLK2, 1'b0, 1'b1, 1'b0);
    wait_digest(0, 0, lat, h);
    $display("[tb] R=1 two-block blk2 lat=%0d hash=%h", lat, h);
    check_value("two_block_hash", h, TWO256);
    take_digest(0);

    // SHA-224 "abc".
    for (int d = 0; d < 3; d++) run_abc(d, 1'b1, ABC224, "abc224");

    // Output backpressure for 20 cycles.
    send_block(0, ABC_BLK, 1'b1, 1'b1, 1'b0);
    wait_digest(0, 0, lat, h);
    stable = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid[0] && out_hash[0] === h && !in_ready[0]) stable++;
    end
    $display("[tb] R=1 backpressure stable_cycles=%0d hash=%h", stable, h);
    check_value("bp_stable", 256'(stable), 256'd20);
    check_value("bp_hash", out_hash[0], ABC256);
    take_digest(0);

    // ena pulsed low for 5 cycles mid-rounds.
    send_block(0, ABC_BLK, 1'b1, 1'b1, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    ena = 1'b0;
    #1;
    check_value("ena_low_ready", {255'h0, in_ready[0]}, 256'h0);
    repeat (5) @(posedge clk);
    #1;
    ena = 1'b1;
    wait_digest(0, 15, lat, h);
    $display("[tb] R=1 ena-stall lat=%0d hash=%h", lat, h);
    check_value("ena_latency", 256'(lat), 256'd70);
    check_value("ena_hash", h, ABC256);
    // Output handshake must not complete while ena is low.
    ena = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    check_value("ena_low_hold_valid", {255'h0, out_valid[0]}, 256'h1);
    ena = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_value("ena_high_take", {255'h0, out_valid[0]}, 256'h0);

    // Reset in the middle of a chained message, then "abc" without first.
    blk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
           $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    send_block(0, blk, 1'b1, 1'b0, 1'b1);
    wait_idle(0, lat);
    send_block(0, blk, 1'b0, 1'b1, 1'b0);
    repeat (30) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_value("midrst_valid", {255'h0, out_valid[0]}, 256'h0);
    check_value("midrst_hash", out_hash[0], 256'h0);
    check_value("midrst_ready", {255'h0, in_ready[0]}, 256'h0);
    rst = 1'b0;
    send_block(0, ABC_BLK, 1'b0, 1'b1, 1'b1);
    wait_digest(0, 0, lat, h);
    $display("[tb] R=1 after-reset abc first=0 lat=%0d hash=%h", lat, h);
    check_value("midrst_chain_hash", h, ABC256);
    take_digest(0);

    // Randomized multi-block messages against the reference model.
    for (int d = 0; d < 3; d++) begin
      m_chain[d] = IV256;
      m_mode[d]  = 1'b0;
      for (int m = 0; m < 4; m++) begin
        nblk = $urandom_range(1, 3);
        for (int b = 0; b < nblk; b++) begin
          blk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                 $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
          first = (b == 0) ? ($urandom_range(3) != 0) : ($urandom_range(5) == 0);
          last  = (b == nblk - 1);
          md    = 1'($urandom_range(1));
          model_block(d, blk, first, last, md, exp);
          send_block(d, blk, first, last, md);
          if (last) begin
            wait_digest(d, 0, lat, h);
            $display("[tb] R=%0d rand msg%0d blk%0d first=%0d mode=%0d lat=%0d hash=%h",
                     1 << d, m, b, first, md, lat, h);
            check_value("rand_hash", h, exp);
            check_value("rand_latency", 256'(lat), 256'((64 >> d) + 1));
            take_digest(d);
          end else begin
            wait_idle(d, lat2);
            $display("[tb] R=%0d rand msg%0d blk%0d first=%0d mode=%0d ready_after=%0d",
                     1 << d, m, b, first, md, lat2);
            check_value("rand_period", 256'(lat2), 256'((64 >> d) + 1));
          end
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
